// File: rtl/hazard_sched.sv
// Stall/flush/forward scheduler for the 5-stage MIPS pipeline.
// It also tracks how long the multi-cycle mult/div unit stays busy.
module hazard_sched #(
  parameter  int unsigned MDU_CYCLES = 32,
  localparam int unsigned CNT_W      = $clog2(MDU_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       PCSrcD,
  input  logic       JumpD,
  input  logic       MdOpD,
  input  logic       MdStartE,
  input  logic       MemAccessM,
  input  logic       DMemReady,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdBusy
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lwstall, branchstall, mdstall, memwait, dstall;

  function automatic logic match(input logic [4:0] x, input logic [4:0] r);
    return (r != 5'd0) && (x == r);
  endfunction

  always_comb begin
    lwstall     = MemtoRegE & (match(RsD, WriteRegE) | match(RtD, WriteRegE));
    branchstall = BranchD &
                  ((RegWriteE & (match(RsD, WriteRegE) | match(RtD, WriteRegE))) |
                   (MemtoRegM & (match(RsD, WriteRegM) | match(RtD, WriteRegM))));
    mdstall     = MdOpD & ((state == MD_BUSY) | MdStartE);
    memwait     = MemAccessM & ~DMemReady;
    dstall      = lwstall | branchstall | mdstall;
  end

  // memwait freezes everything; FlushD is held off while D stalls so the
  // held instruction is not cleared by IF/ID CLR overriding EN.
  always_comb begin
    StallF = ~RST & (memwait | dstall);
    StallD = ~RST & (memwait | dstall);
    StallE = ~RST & memwait;
    StallM = ~RST & memwait;
    FlushW = ~RST & memwait;
    FlushE = ~RST & ~memwait & dstall;
    FlushD = ~RST & ~memwait & ~dstall & (PCSrcD | JumpD);
    MdBusy = ~RST & (state == MD_BUSY);
  end

  always_comb begin
    ForwardAD = RegWriteM & match(RsD, WriteRegM);
    ForwardBD = RegWriteM & match(RtD, WriteRegM);
    ForwardAE = 2'b00;
    if (RegWriteM && match(RsE, WriteRegM))      ForwardAE = 2'b10;
    else if (RegWriteW && match(RsE, WriteRegW)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && match(RtE, WriteRegM))      ForwardBE = 2'b10;
    else if (RegWriteW && match(RtE, WriteRegW)) ForwardBE = 2'b01;
  end

  // The MDU counts down independently of memwait; an issue blocked by
  // memwait stays in E and is retried on the next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (MdStartE && !memwait) begin
            state <= MD_BUSY;
            cnt   <= CNT_W'(MDU_CYCLES - 1);
          end
        end
        MD_BUSY: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: combinational vector table plus
// multi-cycle MDU, memwait and reset sequences.
module tb_hazard_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, PCSrcD, JumpD, MdOpD, MdStartE, MemAccessM, DMemReady;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [13:0] got;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  hazard_sched #(.MDU_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .JumpD(JumpD),
    .MdOpD(MdOpD), .MdStartE(MdStartE),
    .MemAccessM(MemAccessM), .DMemReady(DMemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy)
  );

  // Order: StallF StallD StallE StallM FlushD FlushE FlushW FwdAD FwdBD FwdAE[2] FwdBE[2] MdBusy
  assign got = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy};

  typedef struct packed {
    logic [4:0]  rsd, rtd, rse, rte, wre, wrm, wrw;
    logic        rwe, rwm, rww, mre, mrm, br, pcs, jmp, macc, rdy;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic clr_in();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    MdOpD = 1'b0; MdStartE = 1'b0;
    MemAccessM = 1'b0; DMemReady = 1'b1;
  endtask

  task automatic apply_vec(input vec_t x);
    clr_in();
    RsD = x.rsd; RtD = x.rtd; RsE = x.rse; RtE = x.rte;
    WriteRegE = x.wre; WriteRegM = x.wrm; WriteRegW = x.wrw;
    RegWriteE = x.rwe; RegWriteM = x.rwm; RegWriteW = x.rww;
    MemtoRegE = x.mre; MemtoRegM = x.mrm;
    BranchD = x.br; PCSrcD = x.pcs; JumpD = x.jmp;
    MemAccessM = x.macc; DMemReady = x.rdy;
  endtask

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string name, input logic [13:0] exp);
    @(negedge CLK);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    v = '0; v.mre = 1; v.rwe = 1; v.wre = 5'd1; v.rsd = 5'd1; v.rdy = 1;
    v.exp = 14'b11000100000000; tbl.push_back(v);                 // lwstall on Rs
    v = '0; v.mre = 1; v.rwe = 1; v.rdy = 1;
    v.exp = 14'b00000000000000; tbl.push_back(v);                 // $0 never matches
    v = '0; v.mre = 1; v.rwe = 1; v.wre = 5'd7; v.rtd = 5'd7; v.rdy = 1;
    v.exp = 14'b11000100000000; tbl.push_back(v);                 // lwstall on Rt
    v = '0; v.br = 1; v.pcs = 1; v.rwe = 1; v.wre = 5'd2; v.rsd = 5'd2; v.rdy = 1;
    v.exp = 14'b11000100000000; tbl.push_back(v);                 // branchstall, no flush
    v = '0; v.br = 1; v.pcs = 1; v.rwm = 1; v.wrm = 5'd2; v.rsd = 5'd2; v.rdy = 1;
    v.exp = 14'b00001001000000; tbl.push_back(v);                 // forward to D, flush
    v = '0; v.br = 1; v.pcs = 1; v.mrm = 1; v.rwm = 1; v.wrm = 5'd4; v.rtd = 5'd4; v.rdy = 1;
    v.exp = 14'b11000100100000; tbl.push_back(v);                 // load in M vs branch
    v = '0; v.rwm = 1; v.wrm = 5'd3; v.rww = 1; v.wrw = 5'd3; v.rse = 5'd3; v.rdy = 1;
    v.exp = 14'b00000000010000; tbl.push_back(v);                 // M has priority
    v = '0; v.wrm = 5'd3; v.rww = 1; v.wrw = 5'd3; v.rse = 5'd3; v.rdy = 1;
    v.exp = 14'b00000000001000; tbl.push_back(v);                 // W forward
    v = '0; v.rwm = 1; v.rww = 1; v.wrw = 5'd3; v.rse = 5'd3; v.rdy = 1;
    v.exp = 14'b00000000001000; tbl.push_back(v);                 // RtE=0/WriteRegM=0 -> BE 00
    v = '0; v.rwm = 1; v.wrm = 5'd6; v.rww = 1; v.wrw = 5'd5; v.rte = 5'd5; v.rdy = 1;
    v.exp = 14'b00000000000010; tbl.push_back(v);                 // BE from W
    v = '0; v.rwm = 1; v.wrm = 5'd5; v.rww = 1; v.wrw = 5'd5; v.rte = 5'd5; v.rdy = 1;
    v.exp = 14'b00000000000100; tbl.push_back(v);                 // BE from M
    v = '0; v.jmp = 1; v.rdy = 1;
    v.exp = 14'b00001000000000; tbl.push_back(v);                 // jump flush
    v = '0; v.macc = 1; v.rdy = 0; v.mre = 1; v.wre = 5'd1; v.rsd = 5'd1; v.pcs = 1;
    v.exp = 14'b11110010000000; tbl.push_back(v);                 // memwait dominates
    v = '0; v.macc = 1; v.rdy = 1; v.mre = 1; v.wre = 5'd1; v.rsd = 5'd1; v.pcs = 1;
    v.exp = 14'b11000100000000; tbl.push_back(v);                 // memory ready
    v = '0; v.jmp = 1; v.mre = 1; v.wre = 5'd9; v.rtd = 5'd9; v.rdy = 1;
    v.exp = 14'b11000100000000; tbl.push_back(v);                 // stall blocks flush

    clr_in();
    RST = 1'b1;
    MemtoRegE = 1; WriteRegE = 5'd1; RsD = 5'd1; RegWriteM = 1; WriteRegM = 5'd3;
    RsE = 5'd3; MemAccessM = 1; DMemReady = 0; BranchD = 1; PCSrcD = 1;
    cyc("reset_gate", 14'b00000000010000);
    @(posedge CLK); #1;
    RST = 1'b0;
    clr_in();
    cyc("post_reset", 14'b00000000000000);

    foreach (tbl[i]) begin
      apply_vec(tbl[i]);
      cyc($sformatf("vec%0d", i), tbl[i].exp);
    end

    // mflo in D behind a mult issuing from E
    clr_in();
    MdStartE = 1; MdOpD = 1;
    cyc("md_issue", 14'b11000100000000);
    MdStartE = 0;
    for (int i = 0; i < 4; i++) cyc($sformatf("md_busy%0d", i), 14'b11000100000001);
    cyc("md_done", 14'b00000000000000);

    // issue held by memwait, then memwait during busy
    clr_in();
    MdStartE = 1; MemAccessM = 1; DMemReady = 0;
    cyc("md_held0", 14'b11110010000000);
    cyc("md_held1", 14'b11110010000000);
    DMemReady = 1;
    cyc("md_issue_rdy", 14'b00000000000000);
    MdStartE = 0;
    for (int i = 0; i < 4; i++) begin
      MemAccessM = (i == 1 || i == 2);
      DMemReady  = 0;
      cyc($sformatf("md_wbusy%0d", i), (i == 1 || i == 2) ? 14'b11110010000001
                                                          : 14'b00000000000001);
    end
    clr_in();
    cyc("md_wdone", 14'b00000000000000);

    // MdStartE held through busy must not reload the count
    MdStartE = 1;
    cyc("md_issue3", 14'b00000000000000);
    for (int i = 0; i < 4; i++) cyc($sformatf("md_hold%0d", i), 14'b00000000000001);
    cyc("md_noreload", 14'b00000000000000);
    MdStartE = 0;
    cyc("md_reissue_a", 14'b00000000000001);
    cyc("md_reissue_b", 14'b00000000000001);

    // reset two cycles into busy aborts the op
    RST = 1; MdOpD = 1; MemtoRegE = 1; WriteRegE = 5'd1; RsD = 5'd1;
    cyc("rst_busy", 14'b00000000000000);
    RST = 0; MemtoRegE = 0;
    cyc("after_rst", 14'b00000000000000);
    MdOpD = 0; MdStartE = 1;
    cyc("md_issue4", 14'b00000000000000);
    MdStartE = 0;
    for (int i = 0; i < 4; i++) cyc($sformatf("md_rbusy%0d", i), 14'b00000000000001);
    cyc("md_rdone", 14'b00000000000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
